// File: rtl/card_deck_pkg.sv
// card_deck_pkg: shared FSM states, deck constants and rank-to-face-value mapping
package card_deck_pkg;
    localparam int DECK_SIZE_DEF = 52;
    localparam int RANKS = 13;
    localparam int VALUE_W = 4;
    typedef enum logic [2:0] {
        EMPTY      = 3'd0,
        INIT       = 3'd1,
        SHUFFLE_RD = 3'd2,
        SHUFFLE_WR = 3'd3,
        READY      = 3'd4
    } dealer_state_t;
    function automatic logic [VALUE_W-1:0] rank_to_value(input logic [3:0] rank);
        return (rank >= 4'd9) ? 4'd10 : rank + 4'd1;
    endfunction
endpackage

// File: rtl/card_deck_dealer_lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, taps 16,14,13,11
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);
    // shift right, feedback into the top bit; a non-zero seed never reaches 0
    always_ff @(posedge clk or negedge reset)
        if (!reset) q <= SEED;
        else        q <= {q[0] ^ q[2] ^ q[3] ^ q[5], q[15:1]};
endmodule

// File: rtl/card_deck_dealer.sv
// card_deck_dealer: 52-card deck RAM, LFSR Fisher-Yates shuffle, req/valid dealer (DECK_FIXED_ORDER_EN skips the shuffle)
module card_deck_dealer
    import card_deck_pkg::*;
#(
    parameter int          DECK_SIZE = DECK_SIZE_DEF,
    parameter int          ADDR_W    = 6,
    parameter int          CARD_W    = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shuffle_start,
    input  logic              deal_req,
    output logic              deal_valid,
    output logic [CARD_W-1:0] card,
    output logic              busy,
    output logic [ADDR_W-1:0] cards_left,
    output logic              deck_empty
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DECK_SIZE - 1);
    localparam logic [ADDR_W-1:0] FULL = ADDR_W'(DECK_SIZE);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
    localparam logic [3:0]        RMAX = 4'(RANKS - 1);

    dealer_state_t     state;
    logic [ADDR_W-1:0] idx, ptr, ri, mask, r;
    logic [3:0]        rank, ti, tr;
    logic [3:0]        mem [DECK_SIZE];
    logic [15:0]       lfsr;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .reset(reset), .q(lfsr));

    // smallest all-ones mask covering the current shuffle index
    always_comb begin
        mask = idx;
        for (int k = 1; k < ADDR_W; k++) mask = mask | (idx >> k);
    end

    assign r          = ADDR_W'(lfsr & 16'(mask));
    assign busy       = (state == INIT) || (state == SHUFFLE_RD) || (state == SHUFFLE_WR);
    assign deck_empty = (state != READY) || (cards_left == '0);

    // deck RAM: rank fill during INIT, two-port swap write during SHUFFLE_WR
    always_ff @(posedge clk)
        if (state == INIT) mem[idx] <= rank;
        else if (state == SHUFFLE_WR) begin
            mem[idx] <= tr;
            mem[ri]  <= ti;
        end

    // dealer FSM: fill, shuffle with rejection sampling, then deal one card per request
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state      <= EMPTY;
            idx        <= '0;
            rank       <= '0;
            ptr        <= '0;
            ri         <= '0;
            ti         <= '0;
            tr         <= '0;
            cards_left <= '0;
            deal_valid <= 1'b0;
            card       <= '0;
        end else begin
            deal_valid <= 1'b0;
            case (state)
                EMPTY: if (shuffle_start) begin
                    state <= INIT;
                    idx   <= '0;
                    rank  <= '0;
                end
                INIT: begin
                    idx  <= idx + ONE;
                    rank <= (rank == RMAX) ? 4'd0 : rank + 4'd1;
                    if (idx == LAST) begin
`ifdef DECK_FIXED_ORDER_EN
                        state      <= READY;
                        ptr        <= '0;
                        cards_left <= FULL;
`else
                        state <= SHUFFLE_RD;
                        idx   <= LAST;
`endif
                    end
                end
                SHUFFLE_RD: if (r <= idx) begin
                    ri    <= r;
                    ti    <= mem[idx];
                    tr    <= mem[r];
                    state <= SHUFFLE_WR;
                end
                SHUFFLE_WR: begin
                    idx <= idx - ONE;
                    if (idx == ONE) begin
                        state      <= READY;
                        ptr        <= '0;
                        cards_left <= FULL;
                    end else state <= SHUFFLE_RD;
                end
                READY: if (shuffle_start) begin
                    state      <= INIT;
                    idx        <= '0;
                    rank       <= '0;
                    cards_left <= '0;
                end else if (deal_req && cards_left != '0) begin
                    deal_valid <= 1'b1;
                    card       <= CARD_W'(rank_to_value(mem[ptr]));
                    ptr        <= ptr + ONE;
                    cards_left <= cards_left - ONE;
                end
                default: state <= EMPTY;
            endcase
        end
endmodule
